// File: rtl/interp_linear_nx.sv
// interp_linear_nx
//   Linear interpolator that upsamples CHANNELS parallel sample streams by an
//   integer RATIO. Each clk_en loads a new sample pair (x0 <- x1, x1 <- new).
//   A restoring divide then computes the floor step q and remainder r of
//   (x1 - x0) / RATIO over WIDTH+2 cycles. The RUN phase emits RATIO points,
//   one per clk_en_nx, using a remainder accumulator in place of per-step
//   division.
//
//   Build option: define INTERP_ROUND_EN to start the remainder accumulator at
//   floor(RATIO/2), which gives round-half-up points. Without it the points
//   are pure floor.
//
// Parameters
//   WIDTH     sample width per channel
//   RATIO     interpolation factor, 2..256
//   CHANNELS  parallel channels, channel 0 in the LSBs
//   SIGNED    1: two's-complement samples, 0: unsigned
//
// Ports
//   clk         system clock
//   reset       asynchronous active-low reset
//   clk_en      input-rate strobe; sample_in is valid in that cycle
//   clk_en_nx   output-rate strobe
//   flags_clr   clears the sticky overrun/underrun flags
//   sample_in   new sample x1 per channel
//   sample_out  interpolated sample per channel
//   out_valid   one-cycle pulse per new sample_out
//   end_stage   pulses together with the last (RATIO-th) output
//   busy        high while dividing or running
//   overrun     sticky: clk_en arrived before RATIO outputs were produced
//   underrun    sticky: clk_en_nx arrived outside RUN (or together with clk_en)
module interp_linear_nx #(
    parameter int WIDTH    = 8,
    parameter int RATIO    = 10,
    parameter int CHANNELS = 1,
    parameter int SIGNED   = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clk_en,
    input  logic                      clk_en_nx,
    input  logic                      flags_clr,
    input  logic [CHANNELS*WIDTH-1:0] sample_in,
    output logic [CHANNELS*WIDTH-1:0] sample_out,
    output logic                      out_valid,
    output logic                      end_stage,
    output logic                      busy,
    output logic                      overrun,
    output logic                      underrun
);

    // RW holds any remainder below RATIO plus one headroom bit, so both the
    // divider trial value and rem + r (each < 2*RATIO) fit without overflow.
    localparam int RW = $clog2(RATIO) + 1;
    localparam int KW = $clog2(RATIO);
    localparam int CW = $clog2(WIDTH + 2);

    localparam logic [RW-1:0] RATIO_R = RW'(RATIO);
    localparam logic [KW-1:0] K_LAST  = KW'(RATIO - 1);
    localparam logic [CW-1:0] CNT_FIX = CW'(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);
    localparam logic signed [WIDTH:0] ONE_S = 1;

`ifdef INTERP_ROUND_EN
    localparam logic [RW-1:0] REM_INIT = RW'(RATIO / 2);
`else
    localparam logic [RW-1:0] REM_INIT = '0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_RUN} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [KW-1:0]   k;
    logic            div_step, div_fix, accept, last;
    logic            ovr_set, und_set;

    // Sign- or zero-extend a sample to WIDTH+1 bits.
    function automatic logic signed [WIDTH:0] ext(input logic [WIDTH-1:0] v);
        if (SIGNED != 0) return {v[WIDTH-1], v};
        else             return {1'b0, v};
    endfunction

    // Turn the magnitude quotient into a floor quotient for negative steps.
    function automatic logic signed [WIDTH:0] fix_q(input logic [WIDTH:0] qm,
                                                    input logic [RW-1:0] rm,
                                                    input logic neg);
        if (!neg)          return $signed(qm);
        else if (rm != '0) return -$signed(qm) - ONE_S;
        else               return -$signed(qm);
    endfunction

    // Matching non-negative remainder in [0, RATIO).
    function automatic logic [RW-1:0] fix_r(input logic [RW-1:0] rm,
                                            input logic neg);
        if (neg && rm != '0) return RATIO_R - rm;
        else                 return rm;
    endfunction

    // clk_en always wins over every other action in the same cycle.
    always_comb begin
        div_step = (state == S_DIVIDE) && !clk_en && (cnt <= CNT_MAX);
        div_fix  = (state == S_DIVIDE) && !clk_en && (cnt == CNT_FIX);
        accept   = (state == S_RUN) && clk_en_nx && !clk_en;
        last     = (k == K_LAST);
        ovr_set  = clk_en && (state != S_IDLE);
        und_set  = clk_en_nx && ((state != S_RUN) || clk_en);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (clk_en) begin
            state_nxt = S_DIVIDE;
        end else begin
            case (state)
                S_DIVIDE: if (div_fix) state_nxt = S_RUN;
                S_RUN:    if (accept && last) state_nxt = S_IDLE;
                default:  state_nxt = state;
            endcase
        end
    end

    // Output logic
    always_comb begin
        busy = (state != S_IDLE);
    end

    // Shared control: divide cycle counter, output index, pulses and flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            k         <= '0;
            out_valid <= 1'b0;
            end_stage <= 1'b0;
            overrun   <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            if (clk_en)                   cnt <= '0;
            else if (state == S_DIVIDE)   cnt <= cnt + CW'(1);

            if (div_fix)     k <= '0;
            else if (accept) k <= k + KW'(1);

            out_valid <= accept;
            end_stage <= accept && last;

            if (ovr_set)        overrun <= 1'b1;
            else if (flags_clr) overrun <= 1'b0;

            if (und_set)        underrun <= 1'b1;
            else if (flags_clr) underrun <= 1'b0;
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic signed [WIDTH:0] x0, x1, ext_in, delta, y, q, y_nxt;
        logic [WIDTH:0]        mag, dq, dq_nxt;
        logic [RW-1:0]         pr, trial, pr_nxt, r, rem, rem_sum, rem_nxt;
        logic                  neg, ge, carry;
        logic [WIDTH-1:0]      out_r;

        always_comb begin
            ext_in  = ext(sample_in[ch*WIDTH +: WIDTH]);
            delta   = ext_in - x1;
            mag     = delta[WIDTH] ? $unsigned(-delta) : $unsigned(delta);
            // One restoring-divide step: dq shifts the dividend out MSB first
            // and collects quotient bits in its LSB.
            trial   = {pr[RW-2:0], dq[WIDTH]};
            ge      = (trial >= RATIO_R);
            pr_nxt  = ge ? (trial - RATIO_R) : trial;
            dq_nxt  = {dq[WIDTH-1:0], ge};
            // Remainder accumulator: carry adds the extra unit step.
            rem_sum = rem + r;
            carry   = (rem_sum >= RATIO_R);
            rem_nxt = carry ? (rem_sum - RATIO_R) : rem_sum;
            y_nxt   = y + q + $signed({{WIDTH{1'b0}}, carry});
        end

        // Sample pair and output register
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                x0    <= '0;
                x1    <= '0;
                out_r <= '0;
            end else begin
                if (clk_en) begin
                    x0 <= x1;
                    x1 <= ext_in;
                end
                // y stays within [x0, x1], so dropping the extension bit is lossless.
                if (accept) out_r <= y[WIDTH-1:0];
            end
        end

        // Divider and interpolation datapath; always loaded before use.
        always_ff @(posedge clk) begin
            if (clk_en) begin
                dq  <= mag;
                pr  <= '0;
                neg <= delta[WIDTH];
            end else if (div_step) begin
                dq  <= dq_nxt;
                pr  <= pr_nxt;
            end else if (div_fix) begin
                q   <= fix_q(dq, pr, neg);
                r   <= fix_r(pr, neg);
                y   <= x0;
                rem <= REM_INIT;
            end else if (accept) begin
                y   <= y_nxt;
                rem <= rem_nxt;
            end
        end

        assign sample_out[ch*WIDTH +: WIDTH] = out_r;
    end

endmodule
